// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, core delivery and redirect.
// master = fetch unit, slave = memory plus core.
interface ifu_prefetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: PC generation, single-outstanding imem fetch and a {pc, inst} FIFO.
// Define IFU_TRACE_EN to print dequeued instructions and flag unexpected responses.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  ifu_prefetch_if.master bus
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            active_q;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic req_valid, req_fire, enq, deq, inst_valid;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // In StReq nothing is outstanding, so the credit check reduces to count < DEPTH.
  assign inst_valid = (count_q != '0);
  assign req_valid  = active_q && (state_q == StReq) && (count_q < DepthCnt);
  assign req_fire   = req_valid && bus.imem_req_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    enq        = 1'b0;
    case (state_q)
      StReq: begin
        if (req_fire) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (bus.imem_resp_valid) begin
          enq     = 1'b1;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (bus.imem_resp_valid) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    deq      = inst_valid && bus.inst_ready;
    count_d  = count_q + CntW'(enq) - CntW'(deq);
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    rd_ptr_d = rd_ptr_q + PtrW'(deq);

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      enq        = 1'b0;
      deq        = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Anything still in flight after this cycle belongs to the old stream.
      if (state_d == StWait) state_d = StDrop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      active_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      active_q   <= 1'b1;
      // fetch_pc has already advanced past the outstanding request.
      if (enq) begin
        inst_mem_q[wr_ptr_q] <= bus.imem_resp_data;
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q - 32'd4;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc        = pc_mem_q[rd_ptr_q];

`ifdef IFU_TRACE_EN
  always @(posedge clk) begin
    if (!rst && deq) $display("ifu: pc=%h inst=%h", bus.inst_pc, bus.inst);
    if (!rst && state_q == StReq && bus.imem_resp_valid) begin
      $display("ifu: error: imem response with no request outstanding");
    end
  end
`else
  // Trace hooks compiled out.
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: random-latency memory, stream-level scoreboard
// and directed scenarios for backpressure, redirect, PC wrap and reset.
module tb_ifu_prefetch;
  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int          Depth   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ifu_prefetch_if bus ();

  ifu_prefetch #(.RESET_PC(ResetPc), .DEPTH(Depth)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model knobs and state.
  int          ready_pct = 100;
  int          dly_min   = 1;
  int          dly_max   = 1;
  logic        mem_busy  = 1'b0;
  logic        mem_live  = 1'b0;
  logic [31:0] mem_addr  = '0;
  int          mem_wait  = 0;
  int          n_resp    = 0;
  logic        rst_edge  = 1'b1;

  // Stream model: next address the fetcher should ask for, and the words owed to the core.
  logic [31:0] exp_req_pc = ResetPc;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] deliv_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  always @(posedge clk) rst_edge <= rst;

  // Memory + scoreboard; everything sampled mid-cycle, memory drives for the coming edge.
  always @(negedge clk) begin
    logic resp, fire, deq;
    if (rst) begin
      mem_busy            = 1'b0;
      mem_live            = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.imem_req_ready  = 1'b0;
      exp_q.delete();
      exp_req_pc          = ResetPc;
    end else begin
      resp = mem_busy && (mem_wait == 0);
      if (mem_busy && mem_wait > 0) mem_wait--;
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? mem_word(mem_addr) : $urandom;
      bus.imem_req_ready  = ($urandom_range(0, 99) < ready_pct);

      if (!rst_edge) begin
        n_tests++;
        if (bus.inst_valid !== (exp_q.size() != 0)) begin
          n_fail++;
          $display("FAIL mon_inst_valid: got %b want %b", bus.inst_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
          n_tests++;
          if (bus.inst_pc !== exp_q[0] || bus.inst !== mem_word(exp_q[0])) begin
            n_fail++;
            $display("FAIL mon_head: got pc=%h inst=%h want pc=%h inst=%h",
                     bus.inst_pc, bus.inst, exp_q[0], mem_word(exp_q[0]));
          end
        end
        n_tests++;
        if (bus.imem_req_valid !== (!mem_busy && exp_q.size() < Depth)) begin
          n_fail++;
          $display("FAIL mon_req_valid: got %b want %b", bus.imem_req_valid,
                   !mem_busy && exp_q.size() < Depth);
        end
        if (bus.imem_req_valid === 1'b1) begin
          n_tests++;
          if (bus.imem_req_addr !== exp_req_pc) begin
            n_fail++;
            $display("FAIL mon_req_addr: got %h want %h", bus.imem_req_addr, exp_req_pc);
          end
        end
      end

      fire = bus.imem_req_valid && bus.imem_req_ready;
      deq  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
      if (deq) begin
        deliv_log.push_back(bus.inst_pc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (resp) begin
        mem_busy = 1'b0;
        n_resp++;
        if (mem_live && !bus.redirect_valid) exp_q.push_back(mem_addr);
      end
      if (fire) begin
        n_tests++;
        if (mem_busy) begin
          n_fail++;
          $display("FAIL mon_outstanding: got second request %h want none", bus.imem_req_addr);
        end
        mem_busy = 1'b1;
        mem_live = 1'b1;
        mem_addr = bus.imem_req_addr;
        mem_wait = $urandom_range(dly_max, dly_min) - 1;
        req_log.push_back(bus.imem_req_addr);
        exp_req_pc += 32'd4;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        mem_live   = 1'b0;
        exp_req_pc = {bus.redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int rp, input int dmin, input int dmax, input logic ir);
    ready_pct          = rp;
    dly_min            = dmin;
    dly_max            = dmax;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    rst                = 1'b1;
    repeat (2) next_cycle();
    rst            = 1'b0;
    bus.inst_ready = ir;
    next_cycle();
    req_log.delete();
    deliv_log.delete();
    n_resp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    n_tests += 4;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid);
    end
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
    end
    if (bus.inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst: got %h want 0", bus.inst);
    end
    if (bus.inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst_pc: got %h want 0", bus.inst_pc);
    end
    rst = 1'b0;
    next_cycle();
    n_tests += 2;
    if (bus.imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_req: got %b want 1", bus.imem_req_valid);
    end
    if (bus.imem_req_addr !== ResetPc) begin
      n_fail++; $display("FAIL reset_first_addr: got %h want %h", bus.imem_req_addr, ResetPc);
    end
  endtask

  task automatic test_stream();
    logic        exp_rv, exp_iv;
    logic [31:0] pc;
    apply_reset(100, 1, 1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      exp_rv = (k % 2 == 0);
      exp_iv = (k >= 2) && (k % 2 == 0);
      n_tests += 2;
      if (bus.imem_req_valid !== exp_rv) begin
        n_fail++; $display("FAIL stream_req_valid[%0d]: got %b want %b", k, bus.imem_req_valid, exp_rv);
      end
      if (bus.inst_valid !== exp_iv) begin
        n_fail++; $display("FAIL stream_inst_valid[%0d]: got %b want %b", k, bus.inst_valid, exp_iv);
      end
      if (exp_rv) begin
        pc = ResetPc + 32'(4 * (k / 2));
        n_tests++;
        if (bus.imem_req_addr !== pc) begin
          n_fail++; $display("FAIL stream_req_addr[%0d]: got %h want %h", k, bus.imem_req_addr, pc);
        end
      end
      if (exp_iv) begin
        pc = ResetPc + 32'(4 * (k / 2 - 1));
        n_tests++;
        if (bus.inst_pc !== pc || bus.inst !== mem_word(pc)) begin
          n_fail++;
          $display("FAIL stream_head[%0d]: got %h/%h want %h/%h", k, bus.inst_pc, bus.inst, pc,
                   mem_word(pc));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    apply_reset(100, 1, 1, 1'b0);
    repeat (10) next_cycle();
    n_tests += 4;
    if (req_log.size() != 2) begin
      n_fail++; $display("FAIL bp_req_count: got %0d want 2", req_log.size());
    end else if (req_log[0] !== ResetPc || req_log[1] !== ResetPc + 32'd4) begin
      n_fail++; $display("FAIL bp_req_addrs: got %h %h want %h %h", req_log[0], req_log[1],
                         ResetPc, ResetPc + 32'd4);
    end
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_valid_full: got %b want 0", bus.imem_req_valid);
    end
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== ResetPc) begin
      n_fail++; $display("FAIL bp_head: got %b/%h want 1/%h", bus.inst_valid, bus.inst_pc, ResetPc);
    end
    bus.inst_ready = 1'b1;
    repeat (8) next_cycle();
    n_tests++;
    if (deliv_log.size() < 3 || req_log.size() < 3) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d/%0d want >=3/>=3", deliv_log.size(),
                         req_log.size());
    end else begin
      n_tests += 2;
      for (int i = 0; i < 3; i++) begin
        if (deliv_log[i] !== ResetPc + 32'(4 * i)) begin
          n_fail++; $display("FAIL bp_drain_order[%0d]: got %h want %h", i, deliv_log[i],
                             ResetPc + 32'(4 * i));
        end
      end
      if (req_log[2] !== ResetPc + 32'd8) begin
        n_fail++; $display("FAIL bp_resume_addr: got %h want %h", req_log[2], ResetPc + 32'd8);
      end
    end
  endtask

  task automatic test_redirect_wait();
    int t = 0;
    apply_reset(100, 3, 3, 1'b1);
    while (req_log.size() < 2 && t < 50) begin
      next_cycle();
      t++;
    end
    n_tests++;
    if (req_log.size() < 2) begin
      n_fail++; $display("FAIL rw_timeout: got %0d requests want 2", req_log.size());
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1002;
    next_cycle();
    bus.redirect_valid = 1'b0;
    repeat (20) next_cycle();
    n_tests += 3;
    if (req_log.size() < 3 || req_log[2] !== 32'h8000_1000) begin
      n_fail++; $display("FAIL rw_next_addr: got %h want 80001000",
                         req_log.size() >= 3 ? req_log[2] : 32'hx);
    end
    foreach (deliv_log[i]) begin
      if (deliv_log[i] === ResetPc + 32'd4) begin
        n_fail++; $display("FAIL rw_flushed_delivered: got %h want never", deliv_log[i]);
      end
    end
    if (deliv_log.size() < 2 || deliv_log[1] !== 32'h8000_1000) begin
      n_fail++; $display("FAIL rw_target_delivered: got %h want 80001000",
                         deliv_log.size() >= 2 ? deliv_log[1] : 32'hx);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int t = 0;
    int r0;
    apply_reset(100, 1, 1, 1'b0);
    while (req_log.size() < 2 && t < 50) begin
      next_cycle();
      t++;
    end
    n_tests++;
    if (req_log.size() < 2 || bus.inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL rs_setup: got %0d reqs valid=%b want 2 reqs valid=1",
                         req_log.size(), bus.inst_valid);
    end
    r0                 = n_resp;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    next_cycle();
    bus.redirect_valid = 1'b0;
    n_tests += 3;
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL rs_flush: got inst_valid=%b want 0", bus.inst_valid);
    end
    if (n_resp - r0 != 1) begin
      n_fail++; $display("FAIL rs_resp_same_cycle: got %0d responses want 1", n_resp - r0);
    end
    if (deliv_log.size() != 0) begin
      n_fail++; $display("FAIL rs_head_dropped: got %0d deliveries want 0", deliv_log.size());
    end
    repeat (10) next_cycle();
    n_tests++;
    if (deliv_log.size() < 1 || deliv_log[0] !== 32'h8000_2000) begin
      n_fail++; $display("FAIL rs_target: got %h want 80002000",
                         deliv_log.size() >= 1 ? deliv_log[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    apply_reset(100, 1, 1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hffff_fffd;
    next_cycle();
    bus.redirect_valid = 1'b0;
    n_tests++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_drop_state: got req_valid=%b want 0", bus.imem_req_valid);
    end
    repeat (10) next_cycle();
    n_tests += 2;
    if (req_log.size() < 3 || req_log[1] !== 32'hffff_fffc || req_log[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_req: got %0d reqs want fffffffc then 00000000", req_log.size());
    end
    if (deliv_log.size() < 2 || deliv_log[0] !== 32'hffff_fffc || deliv_log[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_deliv: got %0d deliveries want fffffffc then 00000000",
                         deliv_log.size());
    end
  endtask

  task automatic test_reset_midway();
    apply_reset(100, 5, 5, 1'b1);
    next_cycle();
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || req_log.size() != 1) begin
      n_fail++; $display("FAIL rm_in_wait: got req_valid=%b reqs=%0d want 0/1",
                         bus.imem_req_valid, req_log.size());
    end
    rst = 1'b1;
    next_cycle();
    n_tests += 2;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_req_valid: got %b want 0", bus.imem_req_valid);
    end
    if (bus.inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_inst_valid: got %b want 0", bus.inst_valid);
    end
    rst = 1'b0;
    next_cycle();
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== ResetPc) begin
      n_fail++; $display("FAIL rm_restart: got %b/%h want 1/%h", bus.imem_req_valid,
                         bus.imem_req_addr, ResetPc);
    end
  endtask

  task automatic test_random();
    apply_reset(60, 1, 4, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_pc    = $urandom;
      rst                = (c == 1500 || c == 1501);
      next_cycle();
    end
    bus.redirect_valid = 1'b0;
    rst                = 1'b0;
    n_tests++;
    if (deliv_log.size() < 100) begin
      n_fail++; $display("FAIL random_progress: got %0d deliveries want >=100", deliv_log.size());
    end
  endtask

  initial begin
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_midway();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000 want earlier finish");
    $fatal(1, "watchdog expired");
  end
endmodule
